phys_reg_free_list: RTL and testbench
=====================================

Name: phys_reg_free_list

Overview:
- Manages the pool of unallocated physical registers that feeds the rename table's allocation port.
- Hands out one free preg per accepted allocation.
- Reclaims the previous preg (ppreg) named by each commit notification that writes a register.
- Sits in decode/issue beside the rename table: its alloc_preg drives the rename table's alloc preg input, and commit frees come from the same commit notification the rename table observes.

Parameters:
- p_num_phys_regs, 64, total physical registers; must be >= 33.
- p_phys_addr_bits, $clog2(p_num_phys_regs), preg index width (derived; not overridden).
- (local) capacity = p_num_phys_regs - 32; FIFO depth, equal to the maximum number of simultaneously free pregs.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- alloc_preg  out  p_phys_addr_bits  preg at FIFO head, offered to the allocator.
- alloc_en  in  1  allocation accepted this cycle; legal only when alloc_rdy=1.
- alloc_rdy  out  1  a free preg is available and the block is in RUN.
- free_preg  in  p_phys_addr_bits  ppreg to return (commit ppreg).
- free_val  in  1  free_preg is valid this cycle (commit val && commit wen).
- num_free  out  $clog2(capacity+1)  count of free pregs held.
- err  out  1  sticky illegal-operation flag.

Behaviour:
- Storage: circular FIFO of capacity entries with head/tail pointers and a count.
- Pointers increment modulo capacity: explicit wrap from capacity-1 to 0, because capacity need not be a power of two.
- States: INIT, RUN.
- Reset (rst=0, asynchronous): state=INIT, init counter=0, head=0, tail=0, count=0, err=0. Outputs alloc_rdy=0, num_free=0, alloc_preg=entry[0] (don't-care).
- INIT, one entry per cycle: write entry[i]=32+i, increment count and counter.
  - After the write of i=capacity-1, go to RUN.
  - Tail ends at 0 (wrapped) and count=capacity.
  - INIT lasts exactly capacity cycles after reset release.
- In INIT, alloc_rdy=0. A free_val=1 is dropped and sets err. An alloc_en=1 is ignored and sets err.
- In RUN:
  - alloc_rdy = (count != 0).
  - alloc_preg = entry[head], combinational from registered state; valid whenever alloc_rdy=1.
  - alloc_en && alloc_rdy: head advances at the posedge and count decrements.
  - alloc_en && !alloc_rdy: no state change; err set.
  - free_val && count != capacity: entry[tail] <= free_preg, tail advances, count increments.
  - free_val && count == capacity: free dropped (double free); err set.
- Simultaneous alloc and free in the same cycle with count in 1..capacity-1: both take effect, count unchanged.
- Simultaneous alloc and free with count == capacity: both take effect, because the alloc frees a slot. This is not a double free; count stays at capacity.
- Count == 0: no bypass. A preg freed this cycle becomes allocatable next cycle (alloc_rdy rises one cycle after free_val).
- No content checking of free_preg. Any index, including 0..31, is legal, since architectural initial mappings are later freed as ppregs.
- err stays set until reset.
- Reset asserted mid-INIT or mid-RUN: immediately returns to the reset state and restarts INIT on release. In-flight allocations are lost, and the rename table is reset together with this block.
- Latency: free-to-available 1 cycle; alloc accept-to-next-preg 1 cycle; full throughput of one alloc and one free per cycle.

Test Plan:
- Init, N=36: release rst -> alloc_rdy=0 for 4 cycles; then alloc_rdy=1, num_free=4, alloc_preg=32.
- Drain, N=36: 4 back-to-back allocs -> pregs 32,33,34,35 accepted; afterwards alloc_rdy=0, num_free=0, err=0.
- Reuse at empty: free_val with free_preg=1 -> next cycle alloc_rdy=1, alloc_preg=1; alloc it -> alloc_rdy=0.
- Simultaneous, N=40, after 2 allocs (num_free=6): alloc + free(5) in one cycle -> num_free=6. The pointer wraps after 8 total pops; the entry freed earliest (5) emerges in FIFO order.
- Double free: in RUN with count=capacity, free_val with free_preg=7 -> num_free unchanged, err=1. alloc + free together at full -> err stays 0.
- Reset mid-INIT, N=64: deassert rst, reassert after 10 cycles, release -> alloc_rdy=0 for 32 cycles; first preg 32; num_free=32.

Source files
------------

// File: rtl/phys_reg_free_list_if.sv
// Allocation / free handshake between the rename stage and the physical register free list.
// The master side is the rename logic; the slave side is the free list.
interface phys_reg_free_list_if #(
    parameter int p_phys_addr_bits = 6
);
    logic [p_phys_addr_bits-1:0] alloc_preg;
    logic                        alloc_en;
    logic                        alloc_rdy;
    logic [p_phys_addr_bits-1:0] free_preg;
    logic                        free_val;

    modport master (
        input  alloc_preg,
        input  alloc_rdy,
        output alloc_en,
        output free_preg,
        output free_val
    );

    modport slave (
        output alloc_preg,
        output alloc_rdy,
        input  alloc_en,
        input  free_preg,
        input  free_val
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical registers feeding rename allocation.
// Self-seeds with pregs 32..N-1 after reset; reclaims commit ppregs.
module phys_reg_free_list #(
    parameter int p_num_phys_regs  = 64,
    parameter int p_phys_addr_bits = $clog2(p_num_phys_regs),
    localparam int CAP = p_num_phys_regs - 32,
    localparam int CW  = $clog2(CAP + 1),
    localparam int PW  = (CAP > 1) ? $clog2(CAP) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    phys_reg_free_list_if.slave  fl,
    output logic [CW-1:0]        num_free,
    output logic                 err
);
    localparam int AW = p_phys_addr_bits;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic [PW-1:0]  init_q;
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;
    logic           err_q;
    logic [AW-1:0]  mem [CAP];

    logic           rdy;
    logic           full;
    logic           pop;
    logic           wr_en;
    logic [AW-1:0]  wr_data;
    logic           set_err;

    // Capacity need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(CAP - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full = (count_q == CW'(CAP));

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        pop     = 1'b0;
        wr_en   = 1'b0;
        wr_data = fl.free_preg;
        set_err = 1'b0;
        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_data = AW'(32) + AW'(init_q);
                set_err = fl.alloc_en | fl.free_val;
                if (init_q == PW'(CAP - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rdy     = (count_q != '0);
                pop     = fl.alloc_en & rdy;
                // An alloc in the same cycle frees a slot, so a full push is legal then.
                wr_en   = fl.free_val & (~full | pop);
                set_err = (fl.alloc_en & ~rdy)
                        | (fl.free_val & full & ~pop);
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            init_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) begin
                init_q <= inc(init_q);
            end
            if (pop) begin
                head_q <= inc(head_q);
            end
            if (wr_en) begin
                tail_q <= inc(tail_q);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            err_q <= err_q | set_err;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail_q] <= wr_data;
        end
    end

    assign fl.alloc_rdy  = rdy;
    assign fl.alloc_preg = mem[head_q];
    assign num_free      = count_q;
    assign err           = err_q;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list at N=36, 40 and 64.
// A queue model per instance is compared every cycle; literal checks pin it.
module tb_phys_reg_free_list;
    logic       clk = 1'b0;
    logic [2:0] rstn = '0;
    logic [2:0] al_en = '0;
    logic [2:0] fr_val = '0;
    logic [5:0] fr_preg [3] = '{6'd0, 6'd0, 6'd0};
    logic [2:0] rdy_o;
    logic [2:0] er_o;
    logic [5:0] pr_o [3];
    logic [6:0] nf_o [3];
    bit         chk_on = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int N   = (i == 0) ? 36 : (i == 1) ? 40 : 64;
        localparam int CAP = N - 32;
        localparam int CW  = $clog2(CAP + 1);

        phys_reg_free_list_if #(.p_phys_addr_bits(6)) bus ();
        logic [CW-1:0] nf;

        assign bus.alloc_en  = al_en[i];
        assign bus.free_val  = fr_val[i];
        assign bus.free_preg = fr_preg[i];
        assign rdy_o[i]      = bus.alloc_rdy;
        assign pr_o[i]       = bus.alloc_preg;
        assign nf_o[i]       = 7'(nf);

        phys_reg_free_list #(.p_num_phys_regs(N)) dut (
            .clk      (clk),
            .rst      (rstn[i]),
            .fl       (bus),
            .num_free (nf),
            .err      (er_o[i])
        );

        int q[$];
        int init_left = CAP;
        bit merr = 1'b0;

        initial forever begin
            @(posedge clk or negedge rstn[i]);
            if (!rstn[i]) begin
                q.delete();
                init_left = CAP;
                merr = 1'b0;
            end else if (init_left > 0) begin
                if (al_en[i] || fr_val[i]) merr = 1'b1;
                q.push_back(32 + CAP - init_left);
                init_left--;
            end else begin
                bit pop;
                bit push;
                pop  = al_en[i] && (q.size() != 0);
                push = fr_val[i] && ((q.size() < CAP) || pop);
                if (al_en[i] && q.size() == 0) merr = 1'b1;
                if (fr_val[i] && !push) merr = 1'b1;
                if (pop) void'(q.pop_front());
                if (push) q.push_back(int'(fr_preg[i]));
            end
        end

        initial forever begin
            @(negedge clk);
            if (chk_on) begin
                bit er;
                er = (init_left == 0) && (q.size() != 0);
                chk($sformatf("m%0d_rdy", i), int'(rdy_o[i]), int'(er));
                chk($sformatf("m%0d_nfree", i), int'(nf_o[i]), q.size());
                chk($sformatf("m%0d_err", i), int'(er_o[i]), int'(merr));
                if (er) chk($sformatf("m%0d_preg", i), int'(pr_o[i]), q[0]);
            end
        end
    end

    initial begin
        step(2);
        chk_on = 1'b1;

        // N=36: init then drain
        rstn[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("init36_rdy", int'(rdy_o[0]), 0);
            step(1);
        end
        chk("init36_rdy1", int'(rdy_o[0]), 1);
        chk("init36_nf", int'(nf_o[0]), 4);
        chk("init36_preg", int'(pr_o[0]), 32);
        for (int j = 0; j < 4; j++) begin
            al_en[0] = 1'b1;
            chk("drain_preg", int'(pr_o[0]), 32 + j);
            step(1);
        end
        al_en[0] = 1'b0;
        chk("drain_rdy", int'(rdy_o[0]), 0);
        chk("drain_nf", int'(nf_o[0]), 0);
        chk("drain_err", int'(er_o[0]), 0);

        fr_val[0] = 1'b1;
        fr_preg[0] = 6'd1;
        step(1);
        fr_val[0] = 1'b0;
        chk("reuse_rdy", int'(rdy_o[0]), 1);
        chk("reuse_preg", int'(pr_o[0]), 1);
        al_en[0] = 1'b1;
        step(1);
        al_en[0] = 1'b0;
        chk("reuse_empty", int'(rdy_o[0]), 0);

        for (int j = 0; j < 4; j++) begin
            fr_val[0] = 1'b1;
            fr_preg[0] = 6'(10 + j);
            step(1);
        end
        fr_val[0] = 1'b0;
        chk("fill_nf", int'(nf_o[0]), 4);
        al_en[0] = 1'b1;
        fr_val[0] = 1'b1;
        fr_preg[0] = 6'd20;
        step(1);
        al_en[0] = 1'b0;
        fr_val[0] = 1'b0;
        chk("full_swap_err", int'(er_o[0]), 0);
        chk("full_swap_nf", int'(nf_o[0]), 4);
        chk("full_swap_preg", int'(pr_o[0]), 11);
        fr_val[0] = 1'b1;
        fr_preg[0] = 6'd7;
        step(1);
        fr_val[0] = 1'b0;
        chk("dbl_free_nf", int'(nf_o[0]), 4);
        chk("dbl_free_err", int'(er_o[0]), 1);
        chk("dbl_free_preg", int'(pr_o[0]), 11);

        // N=40: simultaneous alloc/free and pointer wrap
        rstn[1] = 1'b1;
        step(8);
        chk("init40_nf", int'(nf_o[1]), 8);
        chk("init40_preg", int'(pr_o[1]), 32);
        al_en[1] = 1'b1;
        step(2);
        chk("two_alloc_nf", int'(nf_o[1]), 6);
        fr_val[1] = 1'b1;
        fr_preg[1] = 6'd5;
        step(1);
        fr_val[1] = 1'b0;
        chk("simul_nf", int'(nf_o[1]), 6);
        for (int j = 0; j < 6; j++) begin
            chk("wrap_preg", int'(pr_o[1]), (j < 5) ? 35 + j : 5);
            step(1);
        end
        al_en[1] = 1'b0;
        chk("wrap_rdy", int'(rdy_o[1]), 0);
        chk("wrap_nf", int'(nf_o[1]), 0);
        chk("wrap_err", int'(er_o[1]), 0);

        // N=64: illegal alloc in INIT, then reset mid-INIT
        rstn[2] = 1'b1;
        step(3);
        al_en[2] = 1'b1;
        step(1);
        al_en[2] = 1'b0;
        chk("init_alloc_err", int'(er_o[2]), 1);
        step(6);
        rstn[2] = 1'b0;
        #1;
        chk("midrst_rdy", int'(rdy_o[2]), 0);
        chk("midrst_nf", int'(nf_o[2]), 0);
        chk("midrst_err", int'(er_o[2]), 0);
        step(1);
        rstn[2] = 1'b1;
        for (int j = 0; j < 32; j++) begin
            chk("init64_rdy", int'(rdy_o[2]), 0);
            step(1);
        end
        chk("init64_rdy1", int'(rdy_o[2]), 1);
        chk("init64_preg", int'(pr_o[2]), 32);
        chk("init64_nf", int'(nf_o[2]), 32);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
